// File: rtl/sample_window_pkg.sv
// Shared types and sizing helpers for the moving-window delay line
// (sample_window and window_ram).
package nco_window_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2
    } window_state_e;

    function automatic int unsigned depth_of(input int unsigned l);
        return 32'd1 << l;
    endfunction

    // fill_count must represent 0..2**len inclusive
    function automatic int unsigned fill_w(input int unsigned l);
        return l + 1;
    endfunction

endpackage

// File: rtl/sample_window_if.sv
// Sample stream in, first/last pair out, plus window occupancy status.
// master drives samples and flush; slave is the delay line.
interface sample_window_if #(
    parameter int len   = 8,
    parameter int width = 16
);
    logic             in_valid;
    logic [width-1:0] in_sample;
    logic             flush;
    logic [width-1:0] first;
    logic [width-1:0] last;
    logic             out_valid;
    logic             window_full;
    logic [len:0]     fill_count;

    modport master (
        output in_valid, in_sample, flush,
        input  first, last, out_valid, window_full, fill_count
    );

    modport slave (
        input  in_valid, in_sample, flush,
        output first, last, out_valid, window_full, fill_count
    );
endinterface

// File: rtl/sample_window_ram.sv
// Single-port 2**len x width storage for the window; a read returns the
// word that was there before a write to the same address. Not reset.
module window_ram
    import nco_window_pkg::*;
#(
    parameter int len   = 8,
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic [len-1:0]   i_addr,
    input  logic [width-1:0] i_wdata,
    output logic [width-1:0] o_rdata
);
    localparam int DEPTH = depth_of(len);

    logic [width-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_en) begin
            o_rdata        <= r_mem[i_addr];
            r_mem[i_addr]  <= i_wdata;
        end
    end
endmodule

// File: rtl/sample_window.sv
// Moving-window delay line feeding the NCO window accumulator: emits the new
// sample (first) and the sample leaving a 2**len window (last).
// Define SAMPLE_WINDOW_LAST_ALIGN_EN to delay last by one extra cycle.
//
// state | meaning
// EMPTY | no samples held, fill_count = 0
// FILL  | priming, 0 < fill_count < 2**len, last forced to 0
// FULL  | window holds 2**len samples, last comes from RAM
module sample_window
    import nco_window_pkg::*;
#(
    parameter int len   = 8,
    parameter int width = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    sample_window_if.slave  bus
);
    localparam int DEPTH = depth_of(len);
    localparam int FCW   = fill_w(len);

    window_state_e    r_state;
    window_state_e    w_state_nxt;
    logic [len-1:0]   r_wr_ptr;
    logic [FCW-1:0]   r_fill_count;
    logic [width-1:0] r_first;
    logic             r_out_valid;
    logic             r_last_sel;
    logic [width-1:0] w_ram_rdata;
    logic [width-1:0] w_last_s1;
    logic             w_accept;
    logic             w_last_sel_nxt;
    logic             w_full;

    assign w_accept = reset_n & bus.in_valid & ~bus.flush;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: if (w_accept) w_state_nxt = FILL;
                FILL:  if (w_accept && r_fill_count == FCW'(DEPTH - 1)) w_state_nxt = FULL;
                FULL:  w_state_nxt = FULL;
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_comb begin
        w_full         = (r_state == FULL);
        w_last_sel_nxt = w_accept && (r_state == FULL);
    end

    // Flush and reset share one path; reset additionally gates RAM writes.
    always_ff @(posedge clk) begin
        if (!reset_n || bus.flush) begin
            r_wr_ptr     <= '0;
            r_fill_count <= '0;
            r_first      <= '0;
            r_out_valid  <= 1'b0;
            r_last_sel   <= 1'b0;
        end else if (w_accept) begin
            r_wr_ptr     <= r_wr_ptr + 1'b1;
            if (r_fill_count != FCW'(DEPTH)) begin
                r_fill_count <= r_fill_count + 1'b1;
            end
            r_first      <= bus.in_sample;
            r_out_valid  <= 1'b1;
            r_last_sel   <= w_last_sel_nxt;
        end else begin
            r_first      <= '0;
            r_out_valid  <= 1'b0;
            r_last_sel   <= 1'b0;
        end
    end

    window_ram #(
        .len   (len),
        .width (width)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_accept),
        .i_addr  (r_wr_ptr),
        .i_wdata (bus.in_sample),
        .o_rdata (w_ram_rdata)
    );

    // RAM output is already registered; the select zeroes it when idle/priming.
    assign w_last_s1 = r_last_sel ? w_ram_rdata : '0;

`ifdef SAMPLE_WINDOW_LAST_ALIGN_EN
    logic [width-1:0] r_last_s2;

    always_ff @(posedge clk) begin
        if (!reset_n || bus.flush) begin
            r_last_s2 <= '0;
        end else begin
            r_last_s2 <= w_last_s1;
        end
    end

    assign bus.last = r_last_s2;
`else
    assign bus.last = w_last_s1;
`endif

    assign bus.first       = r_first;
    assign bus.out_valid   = r_out_valid;
    assign bus.window_full = w_full;
    assign bus.fill_count  = r_fill_count;

endmodule

// File: tb/tb_sample_window.sv
// Directed bench for sample_window at len=2, width=8; expectations adapt to
// SAMPLE_WINDOW_LAST_ALIGN_EN when the design is built with it.
module tb_sample_window;
    localparam int LEN = 2;
    localparam int WID = 8;
`ifdef SAMPLE_WINDOW_LAST_ALIGN_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         acc;
    logic       acc_clr  = 1'b1;
    logic [7:0] first_d;
    logic [7:0] last_q   = 8'd0;

    sample_window_if #(.len(LEN), .width(WID)) sw ();

    sample_window #(.len(LEN), .width(WID)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (sw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream accumulator; in aligned builds first is delayed one stage
    // so it meets its matching last term.
    always @(posedge clk) begin
        if (acc_clr) acc <= 0;
        else acc <= acc + (ALIGN ? int'(first_d) : int'(sw.first)) - int'(sw.last);
        first_d <= sw.first;
    end

    task automatic cyc(input logic v, input logic [7:0] s, input logic f);
        sw.in_valid  = v;
        sw.in_sample = s;
        sw.flush     = f;
        @(posedge clk);
        #1;
    endtask

    // Expected last seen this cycle, given the last term produced this cycle.
    task automatic adv_last(input logic [7:0] cur, output logic [7:0] shown);
        if (ALIGN) begin
            shown  = last_q;
            last_q = cur;
        end else begin
            shown = cur;
        end
    endtask

    task automatic test_reset();
        logic [20:0] got;
        reset_n = 1'b1;
        acc_clr = 1'b1;
        for (int i = 0; i < 6; i++) cyc(1'($urandom_range(1)), 8'($urandom_range(255)), 1'b0);
        reset_n = 1'b0;
        cyc(1'b1, 8'h55, 1'b0);
        cyc(1'b1, 8'hAA, 1'b0);
        got = {sw.first, sw.last, sw.out_valid, sw.fill_count, sw.window_full};
        n_checks++;
        if (got !== 21'd0) begin
            n_fail++;
            $display("FAIL reset got=%h exp=%h", got, 21'd0);
        end
        reset_n = 1'b1;
        last_q  = 8'd0;
        cyc(1'b0, 8'd0, 1'b0);
        acc_clr = 1'b0;
        got = {sw.first, sw.last, sw.out_valid, sw.fill_count, sw.window_full};
        n_checks++;
        if (got !== 21'd0) begin
            n_fail++;
            $display("FAIL post_reset_idle got=%h exp=%h", got, 21'd0);
        end
    endtask

    task automatic test_fill();
        logic [20:0] got, exp;
        logic [7:0]  el;
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b1, 8'(k), 1'b0);
            adv_last(8'd0, el);
            got = {sw.first, sw.last, sw.out_valid, sw.fill_count, sw.window_full};
            exp = {8'(k), el, 1'b1, 3'(k), (k == 4)};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL fill[%0d] got=%h exp=%h", k, got, exp);
            end
        end
    endtask

    task automatic test_wrap();
        logic [20:0] got, exp;
        logic [7:0]  el;
        for (int s = 5; s <= 6; s++) begin
            cyc(1'b1, 8'(s), 1'b0);
            adv_last(8'(s - 4), el);
            got = {sw.first, sw.last, sw.out_valid, sw.fill_count, sw.window_full};
            exp = {8'(s), el, 1'b1, 3'd4, 1'b1};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL wrap[%0d] got=%h exp=%h", s, got, exp);
            end
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 8'd0, 1'b0);
            adv_last(8'd0, el);
            got = {sw.first, sw.last, sw.out_valid, sw.fill_count, sw.window_full};
            exp = {8'd0, el, 1'b0, 3'd4, 1'b1};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL wrap_idle[%0d] got=%h exp=%h", i, got, exp);
            end
        end
        n_checks++;
        if (acc !== 18) begin
            n_fail++;
            $display("FAIL wrap_acc got=%0d exp=%0d", acc, 18);
        end
    endtask

    task automatic test_idle();
        logic [20:0] got, exp;
        logic [7:0]  el;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 8'hEE, 1'b0);
            adv_last(8'd0, el);
            got = {sw.first, sw.last, sw.out_valid, sw.fill_count, sw.window_full};
            exp = {8'd0, el, 1'b0, 3'd4, 1'b1};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL idle_gap[%0d] got=%h exp=%h", i, got, exp);
            end
        end
        cyc(1'b1, 8'd7, 1'b0);
        adv_last(8'd3, el);
        got = {sw.first, sw.last, sw.out_valid, sw.fill_count, sw.window_full};
        exp = {8'd7, el, 1'b1, 3'd4, 1'b1};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL idle_resume got=%h exp=%h", got, exp);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 8'd0, 1'b0);
            adv_last(8'd0, el);
            got = {sw.first, sw.last, sw.out_valid, sw.fill_count, sw.window_full};
            exp = {8'd0, el, 1'b0, 3'd4, 1'b1};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL idle_drain[%0d] got=%h exp=%h", i, got, exp);
            end
        end
        n_checks++;
        if (acc !== 22) begin
            n_fail++;
            $display("FAIL idle_acc got=%0d exp=%0d", acc, 22);
        end
    endtask

    task automatic test_flush();
        logic [20:0] got, exp;
        logic [7:0]  el;
        acc_clr = 1'b1;
        cyc(1'b1, 8'd9, 1'b1);
        acc_clr = 1'b0;
        last_q  = 8'd0;
        got = {sw.first, sw.last, sw.out_valid, sw.fill_count, sw.window_full};
        n_checks++;
        if (got !== 21'd0) begin
            n_fail++;
            $display("FAIL flush got=%h exp=%h", got, 21'd0);
        end
        for (int s = 10; s <= 13; s++) begin
            cyc(1'b1, 8'(s), 1'b0);
            adv_last(8'd0, el);
            got = {sw.first, sw.last, sw.out_valid, sw.fill_count, sw.window_full};
            exp = {8'(s), el, 1'b1, 3'(s - 9), (s == 13)};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL flush_prime[%0d] got=%h exp=%h", s, got, exp);
            end
        end
        cyc(1'b1, 8'd14, 1'b0);
        adv_last(8'd10, el);
        got = {sw.first, sw.last, sw.out_valid, sw.fill_count, sw.window_full};
        exp = {8'd14, el, 1'b1, 3'd4, 1'b1};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL flush_wrap got=%h exp=%h", got, exp);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 8'd0, 1'b0);
            adv_last(8'd0, el);
        end
        n_checks++;
        if (acc !== 50) begin
            n_fail++;
            $display("FAIL flush_acc got=%0d exp=%0d", acc, 50);
        end
    endtask

    task automatic test_align();
        logic [16:0] got, exp;
        logic [7:0]  el;
        acc_clr = 1'b1;
        cyc(1'b0, 8'd0, 1'b1);
        acc_clr = 1'b0;
        last_q  = 8'd0;
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b1, 8'(k), 1'b0);
            adv_last(8'd0, el);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 8'd0, 1'b0);
            adv_last(8'd0, el);
        end
        n_checks++;
        if (acc !== 10) begin
            n_fail++;
            $display("FAIL align_pre_acc got=%0d exp=%0d", acc, 10);
        end
        cyc(1'b1, 8'd5, 1'b0);
        adv_last(8'd1, el);
        got = {sw.first, sw.last, sw.out_valid};
        exp = {8'd5, el, 1'b1};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL align_first got=%h exp=%h", got, exp);
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (acc !== 10 && acc !== 14) begin
                n_fail++;
                $display("FAIL align_step[%0d] got=%0d exp=10 or 14", i, acc);
            end
            cyc(1'b0, 8'd0, 1'b0);
            adv_last(8'd0, el);
            if (i == 0) begin
                got = {sw.first, sw.last, sw.out_valid};
                exp = {8'd0, ALIGN ? 8'd1 : 8'd0, 1'b0};
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL align_last got=%h exp=%h", got, exp);
                end
            end
        end
        n_checks++;
        if (acc !== 14) begin
            n_fail++;
            $display("FAIL align_acc got=%0d exp=%0d", acc, 14);
        end
    endtask

    initial begin
        reset_n      = 1'b1;
        sw.in_valid  = 1'b0;
        sw.in_sample = 8'd0;
        sw.flush     = 1'b0;
        test_reset();
        test_fill();
        test_wrap();
        test_idle();
        test_flush();
        test_align();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sample_window.md
Name: sample_window

Overview:
- Moving-window delay line that sits directly upstream of the NCO window accumulator.
- For each accepted input sample it presents two values to the accumulator:
  - `first`: the new sample.
  - `last`: the sample leaving a window of 2**len samples.
- The accumulator therefore holds a running sum of the most recent 2**len samples.
- Handles the priming phase (zeros leave the window until it is full), idle cycles and flush.

Parameters:
- len, 8: log2 of the window depth; depth = 2**len samples.
- width, 16: sample width in bits (two's-complement data is passed through unchanged).

Ports:
- clk  input  1  clock
- reset_n  input  1  synchronous, active-low reset
- in_valid  input  1  in_sample is accepted this cycle
- in_sample  input  width  new sample
- flush  input  1  synchronous window clear; takes priority over in_valid
- first  output  width  sample entering the window; 0 when idle
- last  output  width  sample leaving the window; 0 when idle or priming
- out_valid  output  1  first/last correspond to an accepted sample
- window_full  output  1  window holds 2**len samples
- fill_count  output  len+1  number of samples in the window, saturates at 2**len

Behaviour:
- Reset: reset_n is synchronous and active-low; clock is clk. When reset_n=0:
  - first, last, out_valid, window_full and fill_count are all 0.
  - wr_ptr = 0; state = EMPTY.
  - Storage RAM contents are not reset.
- State machine (window_state_e):
  - EMPTY: fill_count = 0.
  - FILL: 0 < fill_count < 2**len.
  - FULL: fill_count = 2**len.
  - EMPTY -> FILL on the first accepted sample.
  - FILL -> FULL on the write that makes fill_count = 2**len.
  - FULL stays in FULL.
  - Any state -> EMPTY on flush or reset.
- Accept (in_valid=1, flush=0):
  - Read mem[wr_ptr] with old-data-on-collision semantics, then write in_sample to mem[wr_ptr].
  - wr_ptr increments and wraps from 2**len-1 to 0.
  - fill_count increments, saturating at 2**len.
- Output latency is 1 cycle from accept:
  - first <= in_sample.
  - last <= old mem[wr_ptr] if the state was FULL at accept, else 0.
  - out_valid <= 1.
- The window_full output equals (state == FULL) and is registered with the state.
- Idle (in_valid=0, flush=0): next cycle first = 0, last = 0, out_valid = 0; wr_ptr and fill_count hold.
- Flush (flush=1):
  - Any sample on that cycle is dropped.
  - Next cycle: wr_ptr = 0, fill_count = 0, state = EMPTY; first, last and out_valid are 0.
  - Old RAM data is never emitted again, because priming forces last = 0.
- Reset mid-operation behaves as flush and additionally clears the output registers the same edge.
- Invariant: summing first - last over all out_valid cycles equals the sum of the newest min(fill_count, 2**len) samples.

Optional Feature:
- Macro: SAMPLE_WINDOW_LAST_ALIGN_EN.
- Defined:
  - last passes through one extra register stage, so its latency is 2 cycles while first stays at 1 cycle.
  - This makes a sample's `last` term reach the downstream two-stage accumulator output in the same cycle as its `first` term, removing the transient one-cycle dip.
  - The extra stage is cleared by reset and flush.
  - out_valid still aligns with first.
- Undefined: first and last are registered together with 1-cycle latency.

Decomposition:
- Package nco_window_pkg:
  - window_state_e enum (EMPTY, FILL, FULL).
  - DEPTH constant function of len.
  - fill_count width helper.
- Sub-module window_ram:
  - Single-port, 2**len x width, synchronous read with old-data-on-same-address-write.
  - No reset.
- The top level holds the pointer, counter, FSM and output/alignment registers.

Test Plan:
All scenarios use len=2 (depth 4), width=8.
1. reset_n low 2 cycles after random traffic -> first=0, last=0, out_valid=0, fill_count=0, window_full=0.
2. Samples 1,2,3,4 on consecutive cycles -> first=1,2,3,4 one cycle later; last=0 each time; fill_count reaches 4; window_full=1 after the 4th.
3. Continue with 5,6 -> last=1,2. Downstream accumulator settles at 3+4+5+6=18.
4. in_valid low 3 cycles, then sample 7 -> first=last=0 and wr_ptr held during the gap; on 7, last=3.
5. flush=1 with in_valid=1, sample 9 -> 9 dropped; fill_count=0. The next 4 samples 10,11,12,13 give last=0; sample 14 gives last=10.
6. Build with SAMPLE_WINDOW_LAST_ALIGN_EN, full window, feed 5 after 1..4 -> last=1 appears one cycle after first=5. Downstream output steps cleanly from 10 to 14 with no intermediate value.
